usb_loop_fifo: RTL and testbench
================================

# usb_loop_fifo

Synchronous first-word-fall-through word FIFO between the read side and the write side of the FX2 slave-FIFO controller (`usb`). OUT-endpoint words read from FDATA are pushed here. The IN-endpoint write path pops them back to the host. It absorbs FLAGA/FLAGD stalls and reports whole-packet availability so the writer bursts full packets. Single clock domain (CLKOUT/IFCLK).

## Interface
- `DATA_W`, 16, word width (FDATA width)
- `ADDR_W`, 9, log2 of capacity; DEPTH = 2^ADDR_W = 512 words
- `AF_MARGIN`, 4, almost_full asserted when level >= DEPTH - AF_MARGIN
- `PKT_WORDS`, 256, pkt_ready asserted when level >= PKT_WORDS (one 512-byte FX2 packet)

- `CLKOUT` in 1: sole clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `clr` in 1: synchronous flush
- `wr_en` in 1: push request
- `wr_data` in DATA_W: push word
- `full` out 1: level == DEPTH
- `almost_full` out 1: level >= DEPTH - AF_MARGIN
- `rd_en` in 1: pop request
- `rd_data` out DATA_W: head word, valid whenever empty == 0
- `empty` out 1: level == 0
- `pkt_ready` out 1: level >= PKT_WORDS
- `level` out ADDR_W+1: words held, 0..DEPTH
- `overflow` out 1: sticky, push attempted while full
- `underflow` out 1: sticky, pop attempted while empty

## Operation
- Storage: DEPTH-entry array, write pointer and read pointer each ADDR_W bits. Pointers wrap modulo DEPTH naturally. The level counter is ADDR_W+1 bits and is the single source of all flags.
- Push is accepted when wr_en && !full, where full is the value before the edge. On acceptance, mem[wp] <= wr_data and wp <= wp+1.
- Pop is accepted when rd_en && !empty, where empty is the value before the edge. On acceptance, rp <= rp+1.
- Level update on each edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- Simultaneous wr_en and rd_en:
  - At 0 < level < DEPTH: both are accepted and level is unchanged.
  - At level == DEPTH: the pop is accepted, the push is rejected, overflow is set, and level becomes DEPTH-1.
  - At level == 0: the push is accepted, the pop is rejected, underflow is set, and level becomes 1.
- Rejected requests never alter storage, pointers or level.
- overflow and underflow stay set until rst or clr.
- clr has priority over wr_en and rd_en in the same cycle. It zeroes wp, rp, level, overflow and underflow. Memory contents are not cleared.
- rd_data is a combinational read of mem[rp] (distributed RAM). It is undefined while empty == 1 and must not be checked then.
- All flags (full, almost_full, empty, pkt_ready) are registered or decoded from the registered level. None depend combinationally on wr_en or rd_en.

## Timing
- Reset values (asynchronous, while rst == 1): level = 0, empty = 1, full = 0, almost_full = 0, pkt_ready = 0, overflow = 0, underflow = 0, wp = rp = 0. rd_data is don't-care.
- Reset mid-operation forces these values immediately, without waiting for a clock edge. The first push after rst deasserts is accepted on the first rising edge.
- Push-to-visible latency: 0 cycles after the accepting edge. Following the edge that pushes into an empty FIFO, empty = 0 and rd_data = the pushed word before the next edge.
- Pop: after the accepting edge, rd_data shows the next word, or empty = 1 if level reached 0.
- Flag transitions occur on the same edge as the level change:
  - full rises on the edge accepting word DEPTH.
  - almost_full rises when level reaches DEPTH - AF_MARGIN (508 at default parameters).
  - pkt_ready rises on the edge accepting word PKT_WORDS and falls on the edge taking level to PKT_WORDS-1.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset: pulse rst for 3 cycles mid-clock, then deassert. Every output must show its reset value immediately, both during and after the pulse.
- Ordering: push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop 3. rd_data must read 0x1111, 0x2222, 0x3333 in order, level must step 3→2→1→0, and empty must rise after the third pop.
- Fill: push 512 words with values 0..511.
  - almost_full rises at level 508 and full at 512.
  - A 513th push of 0xDEAD is rejected: overflow = 1 and level stays 512.
  - Popping all 512 returns 0..511 with 0xDEAD absent.
- Simultaneous events:
  - At level 10, wr_en and rd_en together for 5 cycles keep level at 10.
  - At level 512, both together give level 511 with overflow = 1.
  - At level 0, both together give level 1 with underflow = 1 and rd_data = the pushed word.
- Wrap-around and packet flag:
  - Stream 1500 incrementing words with random rd_en stalls, holding level under 300. Data must match the pushed sequence across pointer wraps.
  - pkt_ready must rise exactly on the edge accepting the 256th held word and fall when level drops to 255.
- Flush and reset: at level 100 with overflow = 1, assert clr together with wr_en. The result must be level = 0, empty = 1, overflow = 0, with the push discarded. Repeat the setup with rst instead of clr; the same values must appear asynchronously.

Source files
------------

// File: rtl/usb_loop_fifo.sv
// First-word-fall-through loopback FIFO between the FX2 OUT-endpoint reader and IN-endpoint writer.
// All flags decode from the registered level; rd_data is a combinational read of the head entry.
module usb_loop_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 9,
  parameter int AF_MARGIN = 4,
  parameter int PKT_WORDS = 256
) (
  input  logic              CLKOUT,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              pkt_ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] LVL_PKT  = (ADDR_W+1)'(PKT_WORDS);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic              push_ok;
  logic              pop_ok;

  assign full        = (level == LVL_FULL);
  assign almost_full = (level >= LVL_AF);
  assign empty       = (level == '0);
  assign pkt_ready   = (level >= LVL_PKT);

  // Acceptance uses the pre-edge flags, so a full FIFO can still pop and an empty one still push.
  assign push_ok = wr_en && !full  && !clr;
  assign pop_ok  = rd_en && !empty && !clr;

  always_ff @(posedge CLKOUT) begin
    if (push_ok) begin
      mem[wp] <= wr_data;
    end
  end

  assign rd_data = mem[rp];

  always_ff @(posedge CLKOUT or posedge rst) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_loop_fifo.sv
// Directed self-checking bench for usb_loop_fifo: reset, ordering, fill, simultaneous ops,
// pointer wrap with packet flag, and flush/reset priority.
module tb_usb_loop_fifo;

  logic        CLKOUT;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        full;
  logic        almost_full;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        pkt_ready;
  logic [9:0]  level;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  usb_loop_fifo #(
    .DATA_W(16), .ADDR_W(9), .AF_MARGIN(4), .PKT_WORDS(256)
  ) dut (
    .CLKOUT(CLKOUT), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .pkt_ready(pkt_ready), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  initial begin
    CLKOUT = 1'b0;
    forever #5 CLKOUT = ~CLKOUT;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock with the given requests; returns 1ns after the edge with requests dropped.
  task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r, input logic c);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    clr     = c;
    @(posedge CLKOUT);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_level"}, 32'(level), 0);
    checkOutput({tag, "_empty"}, 32'(empty), 1);
    checkOutput({tag, "_full"}, 32'(full), 0);
    checkOutput({tag, "_afull"}, 32'(almost_full), 0);
    checkOutput({tag, "_pkt"}, 32'(pkt_ready), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_udf"}, 32'(underflow), 0);
  endtask

  task automatic fillPlain(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    int pushed;
    int popped;
    int mlevel;
    int cycles;
    logic w;
    logic r;

    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

    // Reset pulse mid-clock, checked immediately and after release
    #3 rst = 1'b1;
    #1 checkResetState("rst_during");
    repeat (3) @(posedge CLKOUT);
    #2 checkResetState("rst_held");
    rst = 1'b0;
    #1 checkResetState("rst_after");
    @(posedge CLKOUT);
    #1;

    // Ordering with zero push-to-visible latency
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    checkOutput("ord_first_empty", 32'(empty), 0);
    checkOutput("ord_first_data", 32'(rd_data), 32'h1111);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
    checkOutput("ord_level3", 32'(level), 3);
    checkOutput("ord_head0", 32'(rd_data), 32'h1111);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("ord_level2", 32'(level), 2);
    checkOutput("ord_head1", 32'(rd_data), 32'h2222);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("ord_level1", 32'(level), 1);
    checkOutput("ord_head2", 32'(rd_data), 32'h3333);
    checkOutput("ord_not_empty", 32'(empty), 0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("ord_level0", 32'(level), 0);
    checkOutput("ord_empty", 32'(empty), 1);

    // Fill to capacity, tracking almost_full/full/pkt_ready thresholds
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      checkOutput("fill_level", 32'(level), 32'(i + 1));
      checkOutput("fill_afull", 32'(almost_full), (i + 1 >= 508) ? 32'd1 : 32'd0);
      checkOutput("fill_full", 32'(full), (i + 1 == 512) ? 32'd1 : 32'd0);
      checkOutput("fill_pkt", 32'(pkt_ready), (i + 1 >= 256) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    checkOutput("fill_ovf", 32'(overflow), 1);
    checkOutput("fill_ovf_level", 32'(level), 512);
    for (int i = 0; i < 512; i++) begin
      checkOutput("drain_data", 32'(rd_data), 32'(i));
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(empty), 1);
    checkOutput("drain_ovf_sticky", 32'(overflow), 1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(overflow), 0);

    // Simultaneous push/pop at mid, full and empty levels
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'(32'h100 + i), 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 16'(32'h200 + k), 1'b1, 1'b0);
      checkOutput("both_mid_level", 32'(level), 10);
      checkOutput("both_mid_head", 32'(rd_data), 32'(32'h100 + k + 1));
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    fillPlain(512);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b0);
    checkOutput("both_full_level", 32'(level), 511);
    checkOutput("both_full_ovf", 32'(overflow), 1);
    checkOutput("both_full_full", 32'(full), 0);
    checkOutput("both_full_head", 32'(rd_data), 1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("both_empty_level", 32'(level), 1);
    checkOutput("both_empty_udf", 32'(underflow), 1);
    checkOutput("both_empty_data", 32'(rd_data), 32'hBEEF);
    checkOutput("both_empty_ovf", 32'(overflow), 0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1);
    checkOutput("clr_udf", 32'(underflow), 0);

    // Streaming across pointer wraps with random read stalls
    pushed = 0; popped = 0; mlevel = 0; cycles = 0;
    while (popped < 1500 && cycles < 5000) begin
      w = (pushed < 1500) && (mlevel < 299);
      r = (mlevel > 0) && ($urandom_range(0, 3) != 0);
      if (mlevel > 0) begin
        checkOutput("stream_data", 32'(rd_data), 32'(popped & 16'hFFFF));
      end
      applyStimulus(w, 16'(pushed), r, 1'b0);
      if (w) pushed++;
      if (r) popped++;
      mlevel = pushed - popped;
      cycles++;
      checkOutput("stream_level", 32'(level), 32'(mlevel));
      checkOutput("stream_pkt", 32'(pkt_ready), (mlevel >= 256) ? 32'd1 : 32'd0);
    end
    checkOutput("stream_done", 32'(popped), 1500);
    checkOutput("stream_ovf", 32'(overflow), 0);
    checkOutput("stream_udf", 32'(underflow), 0);

    // Flush priority over a same-cycle push
    fillPlain(512);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 412; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    end
    checkOutput("flush_setup_level", 32'(level), 100);
    checkOutput("flush_setup_ovf", 32'(overflow), 1);
    applyStimulus(1'b1, 16'hCAFE, 1'b0, 1'b1);
    checkResetState("flush");

    // Same setup, then asynchronous reset with a push pending
    fillPlain(512);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 412; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    end
    checkOutput("arst_setup_level", 32'(level), 100);
    #2;
    rst = 1'b1; wr_en = 1'b1; wr_data = 16'hCAFE;
    #1 checkResetState("arst_async");
    @(posedge CLKOUT);
    #2 checkResetState("arst_held");
    rst = 1'b0; wr_en = 1'b0;
    @(posedge CLKOUT);
    #1;
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    checkOutput("arst_push_level", 32'(level), 1);
    checkOutput("arst_push_data", 32'(rd_data), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
